rca_seq_ctrl: RTL and testbench



---
 rtl/rca_seq_pkg.sv | 25 ++
 rtl/rca_seq_ctrl_if.sv | 29 ++
 rtl/add8_slice.sv | 25 ++
 rtl/rca_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_seq_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller.
//   SLICE_W   : width of the single adder slice that is time-multiplexed
//   state_e   : controller state encoding
//   idx_width : width of the slice index counter for a given operand width
package rca_seq_pkg;

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // clog2(width / SLICE_W), never narrower than one bit so WIDTH=8 still has a counter.
    function automatic int unsigned idx_width(int unsigned width);
        int unsigned n;
        n = width / SLICE_W;
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Handshake and data bundle for rca_seq_ctrl.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : controller side (drives in_ready, out_valid, sum, cout, ovf)
interface rca_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/add8_slice.sv
// Combinational 8-bit ripple-carry adder built from explicit full-adder gates.
//   a, b : 8-bit addends
//   cin  : carry into bit 0
//   sum  : 8-bit result
//   cout : carry out of bit 7
module add8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end

    assign cout = c[8];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 8-bit ripple slice is reused LSB-first, one byte per
// cycle, with the carry chained through a register. Valid/ready on both sides.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rca_seq_ctrl_if.slave (in_valid/in_ready, a, b, cin, sub,
//          out_valid/out_ready, sum, cout, ovf)
// Build option: define RCA_SEQ_SUB_EN to honour the sub input (B inverted, carry-in 1).
// Without it the block is add-only and sub is ignored.
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    rca_seq_ctrl_if.slave bus
);

    localparam int unsigned N     = WIDTH / SLICE_W;
    localparam int unsigned IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Operand B and carry-in as seen by the datapath at accept time.
    logic [WIDTH-1:0] b_eff_in;
    logic             cin_eff;

`ifdef RCA_SEQ_SUB_EN
    assign b_eff_in = bus.sub ? ~bus.b : bus.b;
    assign cin_eff  = bus.sub | bus.cin;
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign b_eff_in   = bus.b;
    assign cin_eff    = bus.cin;
`endif

    // Operands shift right one byte per RUN cycle, so the slice always sees bits [7:0].
    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_sum;
    logic               sl_cout;

    assign sl_a = a_q[SLICE_W-1:0];
    assign sl_b = b_q[SLICE_W-1:0];

    add8_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Result bytes enter at the top and shift down; after N steps byte 0 is at the bottom.
    logic [WIDTH-1:0] sum_next;
    assign sum_next = (sum_q >> SLICE_W) | (WIDTH'(sl_sum) << (WIDTH - SLICE_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= b_eff_in;
                        carry_q    <= cin_eff;
                        idx        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE_W;
                    b_q     <= b_q >> SLICE_W;
                    sum_q   <= sum_next;
                    carry_q <= sl_cout;
                    if (idx == LAST_IDX) begin
                        // Top byte is in the slice now: its MSBs are the operand sign bits.
                        cout_q      <= sl_cout;
                        ovf_q       <= (sl_a[SLICE_W-1] == sl_b[SLICE_W-1]) &&
                                       (sl_sum[SLICE_W-1] != sl_a[SLICE_W-1]);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: directed cases with literal results plus randomized
// operations, all checked every cycle against a behavioural model of the handshake timing
// and the arithmetic result.
module tb_rca_seq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int          N     = WIDTH / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rca_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_recv   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference arithmetic: {ovf, cout, sum} from plain wide addition.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic cin, input logic sub);
        logic [WIDTH-1:0] be;
        logic             c;
        logic [WIDTH:0]   full;
        logic             ov;
        be   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, be} + (WIDTH + 1)'(c);
        ov   = (a[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {ov, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    bit               known       = 1'b0;
    bit               busy        = 1'b0;
    bit               reset_clean = 1'b0;
    int               cyc         = 0;
    int               acc_cyc     = 0;
    int               m_delivered = 0;
    logic [WIDTH-1:0] m_sum       = '0;
    logic             m_cout      = 1'b0;
    logic             m_ovf       = 1'b0;
    bit               exp_ov;
    logic             eff_sub;

    always @(negedge clk) begin
        cyc++;
        // A result is due N+1 cycles after the accept cycle and stays until taken.
        exp_ov = busy && ((cyc - acc_cyc) >= (N + 1));
        if (known) begin
            check("in_ready", 64'(bus.in_ready), 64'(!busy));
            check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (exp_ov || reset_clean) begin
                check("sum", 64'(bus.sum), 64'(m_sum));
                check("cout", 64'(bus.cout), 64'(m_cout));
                check("ovf", 64'(bus.ovf), 64'(m_ovf));
            end
        end
`ifdef RCA_SEQ_SUB_EN
        eff_sub = bus.sub;
`else
        eff_sub = 1'b0;
`endif
        if (rst) begin
            known       = 1'b1;
            busy        = 1'b0;
            reset_clean = 1'b1;
            m_sum       = '0;
            m_cout      = 1'b0;
            m_ovf       = 1'b0;
        end else if (known) begin
            if (busy && exp_ov && bus.out_ready) begin
                busy = 1'b0;
                m_delivered++;
            end else if (!busy && bus.in_valid) begin
                busy                  = 1'b1;
                acc_cyc               = cyc;
                reset_clean           = 1'b0;
                {m_ovf, m_cout, m_sum} = ref_add(bus.a, bus.b, bus.cin, eff_sub);
            end
        end
    end

    // ---------------- drivers (called at #1 after a rising edge) ----------------
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        int g;
        g = 0;
        while (!bus.in_ready && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) timeout_fail("send_wait_in_ready");
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic receive(input int delay, input bit noise, output logic [WIDTH-1:0] s,
                           output logic co, output logic ov, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (noise && !bus.in_ready) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a        = WIDTH'($urandom);
                bus.b        = WIDTH'($urandom);
                bus.cin      = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        if (lat >= 100) timeout_fail("receive_wait_out_valid");
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            check("stall_out_valid", 64'(bus.out_valid), 64'(1));
        end
        s             = bus.sum;
        co            = bus.cout;
        ov            = bus.ovf;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_recv++;
        check("in_ready_after_ack", 64'(bus.in_ready), 64'(1));
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic cin, input logic sub,
                            input int delay, input bit noise, input logic [WIDTH-1:0] es,
                            input logic eco, input logic eov);
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        int               lat;
        send(a, b, cin, sub);
        receive(delay, noise, s, co, ov, lat);
        check({name, "_sum"}, 64'(s), 64'(es));
        check({name, "_cout"}, 64'(co), 64'(eco));
        check({name, "_ovf"}, 64'(ov), 64'(eov));
        check({name, "_latency"}, 64'(lat), 64'(N + 1));
    endtask

    function automatic logic [WIDTH-1:0] pick_operand();
        unique case ($urandom_range(0, 4))
            0:       return '1;
            1:       return {1'b1, {(WIDTH - 1){1'b0}}};
            2:       return {1'b0, {(WIDTH - 1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        int               lat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_sum", 64'(bus.sum), 64'(0));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));

        directed("carry_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0,
                 32'h0000_0000, 1'b1, 1'b0);
        directed("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0,
                 32'h8000_0000, 1'b0, 1'b1);
        directed("slice_cin", 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b1,
                 32'h0000_0100, 1'b0, 1'b0);
`ifdef RCA_SEQ_SUB_EN
        directed("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 0, 1'b0, 32'd2, 1'b1, 1'b0);
`else
        directed("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 0, 1'b0, 32'd12, 1'b0, 1'b0);
        directed("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 0, 1'b0, 32'd12, 1'b0, 1'b0);
`endif
        directed("backpressure", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 3, 1'b0,
                 32'h2345_6789, 1'b0, 1'b0);

        // Reset in the second RUN cycle aborts the operation.
        send(32'd1, 32'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_sum", 64'(bus.sum), 64'(0));
        repeat (8) @(posedge clk);
        #1;
        directed("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0, 32'd7, 1'b0, 1'b0);

        // Reset and in_valid on the same edge: nothing is captured.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 32'd9;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_wins_in_ready", 64'(bus.in_ready), 64'(1));
        repeat (N + 3) @(posedge clk);
        #1;
        check("rst_wins_no_result", 64'(bus.out_valid), 64'(0));

        // Randomized operations, occasional mid-operation reset.
        for (int i = 0; i < 150; i++) begin
            send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, N + 2)) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                receive($urandom_range(0, 3), 1'($urandom_range(0, 1)), s, co, ov, lat);
                check("rand_latency", 64'(lat), 64'(N + 1));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        check("result_count", 64'(n_recv), 64'(m_delivered));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
